// File: rtl/rv32_enc_pkg.sv
// Shared opcode constants, field bundle and loader state type for the RV32I encoder/loader.
package rv32_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  // Shift-immediates carry funct7 in the upper immediate bits instead of imm[11:5].
  function automatic logic is_shift_imm(input logic [6:0] op, input logic [2:0] funct3);
    return (op == OP_IMM) && ((funct3 == F3_SLL) || (funct3 == F3_SRX));
  endfunction

endpackage

// File: rtl/rv32_field_encoder.sv
// Combinational RV32I field packer. With ILLEGAL_OP_CHK_EN defined it also flags unlisted opcodes;
// otherwise unlisted opcodes fall through to the R-format packing.
module rv32_field_encoder
  import rv32_enc_pkg::*;
(
  input  fields_t     fields_i,
`ifdef ILLEGAL_OP_CHK_EN
  output logic        legal_o,
`endif
  output logic [31:0] word_o
);

  logic [31:0] imm;
  logic [6:0]  op;

  assign imm = fields_i.imm;
  assign op  = fields_i.op;

  always_comb begin
    word_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3, fields_i.rd, op};
    unique case (op)
      OP_R: ;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: begin
        if (is_shift_imm(op, fields_i.funct3))
          word_o = {fields_i.funct7, imm[4:0], fields_i.rs1, fields_i.funct3, fields_i.rd, op};
        else
          word_o = {imm[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, op};
      end
      OP_STORE:
        word_o = {imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3, imm[4:0], op};
      OP_BRANCH:
        word_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                  imm[4:1], imm[11], op};
      OP_LUI, OP_AUIPC:
        word_o = {imm[31:12], fields_i.rd, op};
      OP_JAL:
        word_o = {imm[20], imm[10:1], imm[11], imm[19:12], fields_i.rd, op};
      default: ;
    endcase
  end

`ifdef ILLEGAL_OP_CHK_EN
  always_comb begin
    legal_o = 1'b0;
    unique case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYS,
      OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: legal_o = 1'b1;
      default: legal_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/rv32_instr_encoder_loader.sv
// Sequential loader: encodes accepted field tuples and writes them to consecutive instruction-memory words.
// Optional ILLEGAL_OP_CHK_EN drops unlisted opcodes and raises a sticky err instead of writing them.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ACCEPT | in_ready high, waiting for a tuple
// WRITE  | mem_we strobe for the captured word, count advances
// DONE   | session finished (last tuple or DEPTH reached), waiting for start
module rv32_instr_encoder_loader
  import rv32_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
`ifdef ILLEGAL_OP_CHK_EN
  output logic              err,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_e              state_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                last_q;

  fields_t             fields;
  logic [31:0]         word;
  logic                op_ok;

  assign fields = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

`ifdef ILLEGAL_OP_CHK_EN
  logic err_q;
  logic legal;

  rv32_field_encoder u_enc (
    .fields_i (fields),
    .legal_o  (legal),
    .word_o   (word)
  );

  assign op_ok = legal;
  assign err   = err_q;
`else
  rv32_field_encoder u_enc (
    .fields_i (fields),
    .word_o   (word)
  );

  assign op_ok = 1'b1;
`endif

  assign count_d = count_q + ONE_C;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      last_q      <= 1'b0;
`ifdef ILLEGAL_OP_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
`ifdef ILLEGAL_OP_CHK_EN
            err_q      <= 1'b0;
`endif
          end
        end
        ACCEPT: begin
          if (in_valid && in_ready_q) begin
            if (op_ok) begin
              state_q     <= WRITE;
              in_ready_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= count_q[ADDR_W-1:0];
              mem_wdata_q <= word;
              last_q      <= in_last;
            end else begin
              // Dropped tuple: nothing written, but a last tuple still closes the session.
`ifdef ILLEGAL_OP_CHK_EN
              err_q <= 1'b1;
`endif
              if (in_last) begin
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          count_q <= count_d;
          if (last_q || (count_d == DEPTH_C)) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            overflow_q <= !last_q;
          end else begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule
